// File: rtl/argmax_ctrl_pkg.sv
// Shared types for the argmax controller: comparator result codes, FSM states
// and a float helper used by the comparator.
package argmax_ctrl_pkg;

    localparam int unsigned FP_W = 32;

    typedef enum logic [1:0] {
        CMP_EQ = 2'b00,
        CMP_GT = 2'b01,
        CMP_LT = 2'b10
    } cmp_res_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FIRST = 2'd1,
        S_SCAN  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // +0 and -0 share a zero magnitude and must compare equal
    function automatic logic fp_is_zero(input logic [FP_W-1:0] x);
        return (x[FP_W-2:0] == '0);
    endfunction

endpackage

// File: rtl/argmax_ctrl_if.sv
// Score stream, result and control handshake bundle for argmax_ctrl.
interface argmax_ctrl_if #(
    parameter int unsigned IDX_W = 4
);
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_index;
    logic [31:0]      out_value;
    logic             busy;

    modport master (
        output start, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_index, out_value, busy
    );

    modport slave (
        input  start, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_index, out_value, busy
    );
endinterface

// File: rtl/argmax_ctrl_cmp.sv
// Combinational IEEE-754 single-precision comparator (NaN not handled):
// reports whether input_x1 is greater than, less than or equal to input_x2.
module cmp
    import argmax_ctrl_pkg::*;
(
    input  logic [FP_W-1:0] input_x1,
    input  logic [FP_W-1:0] input_x2,
    output cmp_res_t        output_result
);

    logic w_s1;
    logic w_s2;
    logic w_mag_gt;
    logic w_both_zero;

    assign w_s1        = input_x1[FP_W-1];
    assign w_s2        = input_x2[FP_W-1];
    assign w_mag_gt    = (input_x1[FP_W-2:0] > input_x2[FP_W-2:0]);
    assign w_both_zero = fp_is_zero(input_x1) && fp_is_zero(input_x2);

    // Sign-magnitude order: larger magnitude wins for positives, loses for negatives
    always_comb begin
        output_result = CMP_EQ;
        if (w_both_zero || (input_x1 == input_x2)) begin
            output_result = CMP_EQ;
        end else if (w_s1 != w_s2) begin
            output_result = w_s1 ? CMP_LT : CMP_GT;
        end else if (!w_s1) begin
            output_result = w_mag_gt ? CMP_GT : CMP_LT;
        end else begin
            output_result = w_mag_gt ? CMP_LT : CMP_GT;
        end
    end

endmodule

// File: rtl/argmax_ctrl.sv
// Streaming argmax over N_CLASSES float32 scores; one shared comparator,
// one comparison per accepted element, result held until taken downstream.
module argmax_ctrl
    import argmax_ctrl_pkg::*;
#(
    parameter int unsigned N_CLASSES = 10,
    parameter int unsigned IDX_W     = 4
) (
    input logic          clk,
    input logic          rst_n,
    argmax_ctrl_if.slave io
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASSES - 1);

    state_t           r_state;
    logic [IDX_W-1:0] r_count;
    logic [FP_W-1:0]  r_best_val;
    logic [IDX_W-1:0] r_best_idx;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;

    logic             w_accept;
    cmp_res_t         w_cmp_res;

    assign w_accept = io.in_valid && r_in_ready;

    cmp u_cmp (
        .input_x1      (io.in_data),
        .input_x2      (r_best_val),
        .output_result (w_cmp_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_best_val  <= '0;
            r_best_idx  <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (io.start) begin
                        r_state    <= S_FIRST;
                        r_count    <= '0;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_FIRST: begin
                    if (w_accept) begin
                        r_best_val <= io.in_data;
                        r_best_idx <= '0;
                        r_count    <= IDX_W'(1);
                        if (N_CLASSES == 1) begin
                            r_state     <= S_DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= S_SCAN;
                        end
                    end
                end
                S_SCAN: begin
                    if (w_accept) begin
                        // Strictly greater only, so ties keep the earlier index
                        if (w_cmp_res == CMP_GT) begin
                            r_best_val <= io.in_data;
                            r_best_idx <= r_count;
                        end
                        r_count <= r_count + 1'b1;
                        if (r_count == LAST_IDX) begin
                            r_state     <= S_DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (io.out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign io.in_ready  = r_in_ready;
    assign io.out_valid = r_out_valid;
    assign io.out_index = r_best_idx;
    assign io.out_value = r_best_val;
    assign io.busy      = r_busy;

endmodule
